// File: rtl/idelay_drp_pkg.sv
// Shared types and constants for the multi-lane IDELAYE3 runtime delay controller.
package idelay_drp_pkg;

    localparam int TAP_W = 9;
    localparam logic [TAP_W-1:0] TAP_MAX = 9'd511;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_READ = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DIS_VTC  = 3'd1,
        WAIT_VTC = 3'd2,
        APPLY    = 3'd3,
        WAIT_CNT = 3'd4,
        RESP     = 3'd5,
        ERR      = 3'd6
    } state_t;

endpackage

// File: rtl/idelay_lane.sv
// One delay lane: an IDELAYE3 in VAR_LOAD mode on FPGA builds, a tap-counter
// model (zero data delay, updates only while VTC is off) in simulation.
module idelay_lane
    import idelay_drp_pkg::*;
#(
    parameter int REFCLK_FREQUENCY = 300,
    parameter     MODE             = "TIME"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_vtc,
    input  logic             load,
    input  logic             ce,
    input  logic             inc,
    input  logic [TAP_W-1:0] cntvaluein,
    output logic [TAP_W-1:0] cntvalueout,
    input  logic             data_in,
    output logic             data_out
);

`ifdef SYNTHESIS
    IDELAYE3 #(
        .CASCADE          ("NONE"),
        .DELAY_FORMAT     (MODE),
        .DELAY_SRC        ("DATAIN"),
        .DELAY_TYPE       ("VAR_LOAD"),
        .DELAY_VALUE      (0),
        .REFCLK_FREQUENCY (REFCLK_FREQUENCY),
        .UPDATE_MODE      ("ASYNC")
    ) u_idelay (
        .CASC_OUT    (),
        .CNTVALUEOUT (cntvalueout),
        .DATAOUT     (data_out),
        .CASC_IN     (1'b0),
        .CASC_RETURN (1'b0),
        .CE          (ce),
        .CLK         (clk),
        .CNTVALUEIN  (cntvaluein),
        .DATAIN      (data_in),
        .EN_VTC      (en_vtc),
        .IDATAIN     (1'b0),
        .INC         (inc),
        .LOAD        (load),
        .RST         (~rst_n)
    );
`else
    if (REFCLK_FREQUENCY > 0 && (MODE == "TIME" || MODE == "COUNT")) begin : g_model
        logic [TAP_W-1:0] tap_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tap_q <= '0;
            end else if (!en_vtc) begin
                // Counter wraps natively, matching the primitive.
                if (load)
                    tap_q <= cntvaluein;
                else if (ce)
                    tap_q <= inc ? tap_q + 1'b1 : tap_q - 1'b1;
            end
        end

        assign cntvalueout = tap_q;
        assign data_out    = data_in;
    end else begin : g_invalid_cfg
        assign cntvalueout = '0;
        assign data_out    = 1'b0;
    end
`endif

endmodule

// File: rtl/idelay_multi_drp.sv
// Request/response controller sequencing VTC-off, tap update and readback for NUM_CH lanes.
// Optional IDELAY_MULTI_SAT_EN rejects INC at the top tap and DEC at tap 0.
module idelay_multi_drp
    import idelay_drp_pkg::*;
#(
    parameter int  NUM_CH           = 4,
    parameter int  REFCLK_FREQUENCY = 300,
    parameter      MODE             = "TIME",
    parameter bit  VTC_DEFAULT      = 1'b1,
    parameter int  SETTLE_CYCLES    = 16,
    localparam int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] data_in,
    output logic [NUM_CH-1:0] data_out,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [CH_W-1:0]   req_ch,
    input  logic [TAP_W-1:0]  req_delay,
    output logic              rsp_valid,
    output logic [CH_W-1:0]   rsp_ch,
    output logic [TAP_W-1:0]  rsp_delay,
    output logic              rsp_err
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [TAP_W-1:0] delay_q, delay_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]  rsp_ch_q, rsp_ch_d;
    logic [TAP_W-1:0] rsp_delay_q, rsp_delay_d;

    logic [TAP_W-1:0] lane_cnt [NUM_CH];
    logic [NUM_CH-1:0] lane_en_vtc;
    logic [NUM_CH-1:0] lane_load;
    logic [NUM_CH-1:0] lane_ce;
    logic              ch_ok;
    logic [TAP_W-1:0]  cur_cnt;
    logic              vtc_off;
`ifdef IDELAY_MULTI_SAT_EN
    logic [TAP_W-1:0]  req_cnt;
    logic              sat_hit;
`endif

    // Range check by match rather than compare keeps it valid for any NUM_CH.
    always_comb begin
        ch_ok   = 1'b0;
        cur_cnt = '0;
`ifdef IDELAY_MULTI_SAT_EN
        req_cnt = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_ch == CH_W'(i)) begin
                ch_ok = 1'b1;
`ifdef IDELAY_MULTI_SAT_EN
                req_cnt = lane_cnt[i];
`endif
            end
            if (ch_q == CH_W'(i))
                cur_cnt = lane_cnt[i];
        end
    end

`ifdef IDELAY_MULTI_SAT_EN
    assign sat_hit = (op_t'(req_op) == OP_INC && req_cnt == TAP_MAX) ||
                     (op_t'(req_op) == OP_DEC && req_cnt == '0);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ch_d        = ch_q;
        delay_d     = delay_q;
        cnt_d       = cnt_q;
        rsp_ch_d    = rsp_ch_q;
        rsp_delay_d = rsp_delay_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = op_t'(req_op);
                    ch_d    = req_ch;
                    delay_d = req_delay;
                    cnt_d   = SETTLE_LAST;
                    if (!ch_ok)
                        state_d = ERR;
                    else if (op_t'(req_op) == OP_READ)
                        state_d = WAIT_CNT;
`ifdef IDELAY_MULTI_SAT_EN
                    else if (sat_hit)
                        state_d = ERR;
`endif
                    else
                        state_d = DIS_VTC;
                end
            end
            DIS_VTC: begin
                state_d = WAIT_VTC;
                cnt_d   = SETTLE_LAST;
            end
            WAIT_VTC: begin
                if (cnt_q == '0)
                    state_d = APPLY;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            APPLY: begin
                state_d = WAIT_CNT;
                cnt_d   = SETTLE_LAST;
            end
            WAIT_CNT: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_ch_d    = ch_q;
                    rsp_delay_d = cur_cnt;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_LOAD;
            ch_q        <= '0;
            delay_q     <= '0;
            cnt_q       <= '0;
            rsp_ch_q    <= '0;
            rsp_delay_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ch_q        <= ch_d;
            delay_q     <= delay_d;
            cnt_q       <= cnt_d;
            rsp_ch_q    <= rsp_ch_d;
            rsp_delay_q <= rsp_delay_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP) || (state_q == ERR);
    assign rsp_err   = (state_q == ERR);
    assign rsp_ch    = rsp_ch_q;
    assign rsp_delay = rsp_delay_q;

    // READ never drops VTC; modifying ops hold it off until the readback settles.
    assign vtc_off = (state_q inside {DIS_VTC, WAIT_VTC, APPLY, WAIT_CNT}) && (op_q != OP_READ);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        logic sel;
        assign sel             = (ch_q == CH_W'(gi));
        assign lane_en_vtc[gi] = (sel && vtc_off) ? 1'b0 : VTC_DEFAULT;
        assign lane_load[gi]   = sel && (state_q == APPLY) && (op_q == OP_LOAD);
        assign lane_ce[gi]     = sel && (state_q == APPLY) && (op_q == OP_INC || op_q == OP_DEC);

        idelay_lane #(
            .REFCLK_FREQUENCY (REFCLK_FREQUENCY),
            .MODE             (MODE)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .en_vtc      (lane_en_vtc[gi]),
            .load        (lane_load[gi]),
            .ce          (lane_ce[gi]),
            .inc         (op_q == OP_INC),
            .cntvaluein  (delay_q),
            .cntvalueout (lane_cnt[gi]),
            .data_in     (data_in[gi]),
            .data_out    (data_out[gi])
        );
    end

endmodule

// File: tb/tb_idelay_multi_drp.sv
// Scoreboard bench: driver predicts each response from a tap-array model, monitor checks it.
module tb_idelay_multi_drp;

    localparam int NCH    = 3;
    localparam int SETTLE = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] data_in = '0;
    logic [NCH-1:0] data_out;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_op = 2'd0;
    logic [1:0]     req_ch = 2'd0;
    logic [8:0]     req_delay = 9'd0;
    logic           rsp_valid;
    logic [1:0]     rsp_ch;
    logic [8:0]     rsp_delay;
    logic           rsp_err;

    idelay_multi_drp #(
        .NUM_CH           (NCH),
        .REFCLK_FREQUENCY (300),
        .MODE             ("TIME"),
        .VTC_DEFAULT      (1'b1),
        .SETTLE_CYCLES    (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_out  (data_out),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ch    (req_ch),
        .req_delay (req_delay),
        .rsp_valid (rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_delay (rsp_delay),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int ch;
        int dly;
        int err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   tot_ce = 0;
    int   tot_ld = 0;
    int   tot_vtc = 0;

    // reference model state
    int tap[NCH];
    int last_ch = 0;
    int last_dly = 0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        tot_ce  <= tot_ce + $countones(dut.lane_ce);
        tot_ld  <= tot_ld + $countones(dut.lane_load);
        tot_vtc <= tot_vtc + $countones(~dut.lane_en_vtc);
    end

    // Monitor: every response pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_cycle", cyc, mon_e.due);
                chk("rsp_err", int'(rsp_err), mon_e.err);
                chk("rsp_ch", int'(rsp_ch), mon_e.ch);
                chk("rsp_delay", int'(rsp_delay), mon_e.dly);
            end
        end
    end

    // Model: op 0 LOAD, 1 READ, 2 INC, 3 DEC; taps 0..511 wrapping.
    task automatic predict(input int op, input int ch, input int d, input int c0,
                           output int vtc, output int ld, output int ce);
        exp_t e;
        bit   err;
        err = (ch >= NCH);
`ifdef IDELAY_MULTI_SAT_EN
        if (!err && op == 2 && tap[ch] == 511) err = 1;
        if (!err && op == 3 && tap[ch] == 0) err = 1;
`endif
        vtc = 0; ld = 0; ce = 0;
        if (err) begin
            e.due = c0 + 1;
        end else begin
            case (op)
                0: tap[ch] = d;
                2: tap[ch] = (tap[ch] + 1) % 512;
                3: tap[ch] = (tap[ch] + 511) % 512;
                default: ;
            endcase
            if (op == 1) begin
                e.due = c0 + SETTLE + 1;
            end else begin
                e.due = c0 + 2 * SETTLE + 3;
                vtc   = 2 * SETTLE + 2;
                ld    = (op == 0) ? 1 : 0;
                ce    = (op == 0) ? 0 : 1;
            end
            last_ch  = ch;
            last_dly = tap[ch];
        end
        e.err = err;
        e.ch  = last_ch;
        e.dly = last_dly;
        sbq.push_back(e);
    endtask

    task automatic issue(input int op, input int ch, input int d, input bit junk);
        int c0, n, vtc, ld, ce, ce0, ld0, vtc0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_wait_timeout", 0, 1);
        c0 = cyc;
        ce0 = tot_ce; ld0 = tot_ld; vtc0 = tot_vtc;
        predict(op, ch, d, c0, vtc, ld, ce);
        req_op    = 2'(op);
        req_ch    = 2'(ch);
        req_delay = 9'(d);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_drop", int'(req_ready), 0);
        if (junk) begin
            req_op    = 2'($urandom_range(0, 3));
            req_ch    = 2'($urandom_range(0, 3));
            req_delay = 9'($urandom_range(0, 511));
        end else begin
            req_valid = 1'b0;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                chk("busy_timeout", 0, 1);
                break;
            end
        end
        req_valid = 1'b0;
        #1;
        $display("tx op=%0d ch=%0d d=%0d accepted_cycle=%0d", op, ch, d, c0);
        chk("vtc_off_cycles", tot_vtc - vtc0, vtc);
        chk("load_pulses", tot_ld - ld0, ld);
        chk("ce_pulses", tot_ce - ce0, ce);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NCH; i++) tap[i] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", int'(req_ready), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_err", int'(rsp_err), 0);
        chk("reset_rsp_ch", int'(rsp_ch), 0);
        chk("reset_rsp_delay", int'(rsp_delay), 0);
        chk("reset_en_vtc", int'(dut.lane_en_vtc), 7);

        issue(1, 0, 0, 0);
        issue(0, 2, 137, 0);
        for (int c = 0; c < NCH; c++) issue(1, c, 0, 0);
        issue(0, 1, 200, 0);
        issue(2, 1, 0, 0);
        issue(2, 1, 0, 0);
        issue(3, 1, 0, 0);
        issue(0, 1, 55, 0);
        issue(1, NCH, 9, 0);
        issue(0, 0, 511, 0);
        issue(2, 0, 0, 0);
        issue(1, 0, 0, 0);
        issue(0, 2, 0, 0);
        issue(3, 2, 0, 0);
        issue(1, 2, 0, 1);

        for (int k = 0; k < 40; k++) begin
            int op, ch;
            op = $urandom_range(0, 3);
            ch = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                ch = 0;
                op = 2 + $urandom_range(0, 1);
                issue(0, ch, (op == 2) ? 511 : 0, 0);
            end
            issue(op, ch, $urandom_range(0, 511), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a LOAD: no response, taps back to 0.
        @(negedge clk);
        req_op = 2'd0; req_ch = 2'd2; req_delay = 9'd300; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NCH; i++) tap[i] = 0;
        last_ch = 0;
        last_dly = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("tx reset-abort of LOAD ch=2 at cycle %0d", cyc);
        chk("abort_ready", int'(req_ready), 1);
        chk("abort_rsp_ch", int'(rsp_ch), 0);
        chk("abort_rsp_delay", int'(rsp_delay), 0);
        repeat (40) @(negedge clk);
        issue(1, 2, 0, 0);
        issue(1, 1, 0, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
